// File: rtl/fpadd_arbiter.sv
// Round-robin share of one combinational FP32 adder among N requesters; accept-to-rsp_valid is one cycle.
// Two-entry pipeline (S1 issue, S2 result): requesters stall only once both stages are held by rsp_ready=0.

module mainmodule (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);
    logic        sx, sy, swap, stk, up, lz_done;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  fx, fy;
    logic [9:0]  ex, ey, er, d;
    logic [26:0] mx, my, mys, nrm;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [24:0] rnd;

    always_comb begin
        a_nan = (&a[30:23]) & (|a[22:0]);
        b_nan = (&b[30:23]) & (|b[22:0]);
        a_inf = (&a[30:23]) & ~(|a[22:0]);
        b_inf = (&b[30:23]) & ~(|b[22:0]);

        // x is the operand of larger magnitude, so the aligned difference never goes negative
        swap = b[30:0] > a[30:0];
        sx   = swap ? b[31] : a[31];
        sy   = swap ? a[31] : b[31];
        fx   = swap ? b[30:23] : a[30:23];
        fy   = swap ? a[30:23] : b[30:23];
        mx   = {fx != 8'd0, swap ? b[22:0] : a[22:0], 3'b000};
        my   = {fy != 8'd0, swap ? a[22:0] : b[22:0], 3'b000};
        ex   = {2'b00, (fx == 8'd0) ? 8'd1 : fx};
        ey   = {2'b00, (fy == 8'd0) ? 8'd1 : fy};
        d    = ex - ey;

        if (d >= 10'd27) begin
            mys = '0;
            stk = |my;
        end else begin
            mys = my >> d;
            stk = |(my & ((27'd1 << d) - 27'd1));
        end
        mys[0] = mys[0] | stk;

        sum = (sx == sy) ? ({1'b0, mx} + {1'b0, mys}) : ({1'b0, mx} - {1'b0, mys});

        lz      = 5'd27;
        lz_done = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_done && sum[i]) begin
                lz      = 5'(26 - i);
                lz_done = 1'b1;
            end
        end

        sh = '0;
        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            er  = ex + 10'd1;
        end else begin
            // never shift below the minimum exponent: the result becomes subnormal instead
            sh  = ({5'd0, lz} > (ex - 10'd1)) ? 5'(ex - 10'd1) : lz;
            nrm = sum[26:0] << sh;
            er  = ex - {5'd0, sh};
        end

        up  = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        rnd = {1'b0, nrm[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            er  = er + 10'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            res = 32'h7FC0_0000;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (sum == 28'd0)
            res = {a[31] & b[31], 31'd0};
        else if (er >= 10'd255)
            res = {sx, 8'hFF, 23'd0};
        else
            res = {sx, rnd[23] ? er[7:0] : 8'd0, rnd[22:0]};
    end
endmodule

module fpadd_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [31:0]     rsp_res,
    output logic [31:0]     op_count
);
    typedef struct packed {
        logic [31:0]    a;
        logic [31:0]    b;
        logic [IDW-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [31:0]    res;
        logic [IDW-1:0] id;
    } s2_t;

    logic           s1_v, s2_v;
    s1_t            s1;
    s2_t            s2;
    logic [IDW-1:0] ptr, winner, ptr_nxt;
    logic [IDW:0]   cand;
    logic           found, can_accept, accept, s1_adv, s2_adv;
    logic [31:0]    core_res;

    mainmodule u_core (
        .a   (s1.a),
        .b   (s1.b),
        .res (core_res)
    );

    // cand is one bit wider than ptr so ptr+k never aliases before the explicit wrap compare
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N))
                cand = cand - (IDW+1)'(N);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        s2_adv     = !s2_v | rsp_ready;
        s1_adv     = s1_v & s2_adv;
        can_accept = !s1_v | s2_adv;
        accept     = found & can_accept & !rst;
        ptr_nxt    = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
        req_ready  = '0;
        if (accept)
            req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1   <= '0;
            ptr  <= '0;
        end else if (accept) begin
            s1_v <= 1'b1;
            s1   <= '{a: req_a[32*winner +: 32], b: req_b[32*winner +: 32], id: winner};
            ptr  <= ptr_nxt;
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2   <= '0;
        end else if (s1_adv) begin
            s2_v <= 1'b1;
            s2   <= '{res: core_res, id: s1.id};
        end else if (rsp_ready) begin
            s2_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (s2_v && rsp_ready)
            op_count <= op_count + 32'd1;
    end

    assign rsp_valid = s2_v;
    assign rsp_res   = s2.res;
    assign rsp_id    = s2.id;
endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: queue-based reference of grants, in-flight results and response order.
module tb_fpadd_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_res;
    logic [31:0]     op_count;

    always #5 clk = ~clk;

    fpadd_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .op_count  (op_count)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        int          acc;
    } ent_t;

    ent_t        fl[$];
    logic        cur_v[N];
    logic [31:0] cur_a[N], cur_b[N], cur_r[N];
    logic        rdy;
    int          ptr_m, now, errors, checks, last_grant, last_rsp;
    logic [31:0] cnt_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, now);
        end
    endtask

    // value k/256 as an IEEE single; exact for |k| < 2^24
    function automatic logic [31:0] to_float(input int k);
        logic        s;
        int unsigned m;
        int          p;
        logic [31:0] mm;
        logic [7:0]  e;
        if (k == 0) return 32'h0;
        s = (k < 0);
        m = s ? -k : k;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        mm = m << (23 - p);
        e  = 8'(127 + p - 8);
        return {s, e, mm[22:0]};
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        cur_v[i] = 1'b1;
        cur_a[i] = a;
        cur_b[i] = b;
        cur_r[i] = r;
    endtask

    task automatic rand_op(input int i);
        int ka, kb;
        case ($urandom_range(3))
            0: begin ka = int'($urandom_range(2000)) - 1000; kb = int'($urandom_range(2000)) - 1000; end
            1: begin ka = int'($urandom_range(1 << 20)) - (1 << 19); kb = int'($urandom_range(1 << 20)) - (1 << 19); end
            2: begin ka = int'($urandom_range(1 << 20)) - (1 << 19); kb = -ka + int'($urandom_range(8)) - 4; end
            default: begin ka = int'($urandom_range(1 << 20)) - (1 << 19); kb = int'($urandom_range(20)) - 10; end
        endcase
        set_op(i, to_float(ka), to_float(kb), to_float(ka + kb));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = cur_v[i];
            req_a[32*i +: 32]  = cur_a[i];
            req_b[32*i +: 32]  = cur_b[i];
        end
        rsp_ready = rdy;
    endtask

    // one clock: drive after negedge, compare against the model, then retire model events at posedge
    task automatic step();
        int          n, win;
        bit          vis, hs, acc;
        logic [N-1:0] er;
        drive();
        #1;
        n   = fl.size();
        vis = (n > 0) && (fl[0].acc < now);
        hs  = vis && rdy;
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && cur_v[(ptr_m + k) % N]) win = (ptr_m + k) % N;
        acc = (win >= 0) && ((n - int'(hs)) < 2);
        er  = '0;
        if (acc) er[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(vis));
        if (vis) begin
            chk("rsp_id", 32'(rsp_id), 32'(fl[0].id));
            chk("rsp_res", rsp_res, fl[0].res);
        end
        chk("op_count", op_count, cnt_m);
        @(posedge clk);
        now++;
        last_grant = -1;
        last_rsp   = -1;
        if (hs) begin
            last_rsp = fl[0].id;
            void'(fl.pop_front());
            cnt_m = cnt_m + 32'd1;
        end
        if (acc) begin
            fl.push_back('{win, cur_r[win], now});
            cur_v[win] = 1'b0;
            ptr_m      = (win + 1) % N;
            last_grant = win;
        end
        @(negedge clk);
    endtask

    // called just after a negedge: raise rst between edges and expect immediate clearing
    task automatic reset_mid(input int hold);
        drive();
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        fl.delete();
        ptr_m = 0;
        cnt_m = '0;
        repeat (hold) @(posedge clk);
        now += hold;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; now = 0; ptr_m = 0; cnt_m = '0;
        last_grant = -1; last_rsp = -1; rdy = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);

        // reset with every requester asserting valid
        @(negedge clk);
        reset_mid(2);
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;

        // single op: 1.0 + 2.0
        rdy = 1'b1;
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        step(); chk("single_grant", 32'(last_grant), 32'd0);
        step(); chk("single_nohs", 32'(last_rsp), 32'hFFFF_FFFF);
        step(); chk("single_rsp_id", 32'(last_rsp), 32'd0);
        chk("single_count", op_count, 32'd1);

        // round-robin fairness with all requesters saturated
        reset_mid(1);
        rdy = 1'b1;
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < N; i++)
                if (!cur_v[i]) set_op(i, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
            step();
            chk("rr_grant", 32'(last_grant), 32'(j % 4));
            if (j >= 2) chk("rr_rsp_id", 32'(last_rsp), 32'((j - 2) % 4));
        end
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        repeat (3) step();

        // backpressure: two accepts then full stall, then in-order drain
        reset_mid(1);
        rdy = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (!cur_v[1]) set_op(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
            if (!cur_v[2]) set_op(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
            step();
            chk("bp_grant", 32'(last_grant), (j == 0) ? 32'd1 : (j == 1) ? 32'd2 : 32'hFFFF_FFFF);
        end
        rdy = 1'b1;
        step(); chk("bp_drain0", 32'(last_rsp), 32'd1);
        step(); chk("bp_drain1", 32'(last_rsp), 32'd2);
        repeat (4) step();

        // pointer skip
        reset_mid(1);
        rdy = 1'b1;
        set_op(0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000);
        step(); chk("skip_g0", 32'(last_grant), 32'd0);
        set_op(3, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000);
        step(); chk("skip_g3", 32'(last_grant), 32'd3);
        set_op(0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000);
        set_op(2, 32'h4120_0000, 32'hC120_0000, 32'h0000_0000);
        step(); chk("skip_g0b", 32'(last_grant), 32'd0);
        step(); chk("skip_g2", 32'(last_grant), 32'd2);
        repeat (3) step();

        // reset mid-flight with two ops held and a third requester waiting
        rdy = 1'b0;
        set_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        set_op(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        step(); step();
        set_op(2, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        reset_mid(2);
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        rdy = 1'b1;
        repeat (3) step();
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);

        // op_count wrap via preload
        rdy = 1'b0;
        set_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        step(); step();
        force dut.op_count = 32'hFFFF_FFFF;
        #1;
        release dut.op_count;
        cnt_m = 32'hFFFF_FFFF;
        rdy = 1'b1;
        step();
        chk("wrap_count", op_count, 32'h0000_0000);
        step();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if (!cur_v[i] && $urandom_range(99) < 45) rand_op(i);
            rdy = ($urandom_range(99) < 65);
            if (c == 1000) reset_mid(1);
            step();
        end
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        rdy = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
